// File: rtl/key_sched_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule controller: round count,
// FSM state encodings, Rcon table and the GF(2^8) S-box helpers.
package key_sched_ctrl_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int NUM_ROUNDS_DEF = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] rc);
        logic [7:0] r;
        r = 8'h00;
        if (rc < 4'd10) r = RCON[rc];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse computed as a^254 (0 maps to 0), followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_sched_ctrl_expand_step.sv
// One AES-128 key expansion round: derives round key rc+1 from round key rc.
module key_expand_step
    import key_sched_ctrl_pkg::*;
(
    input  logic [127:0] inkey,
    input  logic [3:0]   rc,
    output logic [127:0] outkey
);

    word_t w0, w1, w2, w3;
    word_t rot_w, sub_w, tmp_w;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = inkey;

    assign rot_w = {w3[23:0], w3[31:24]};
    assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                    sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    assign tmp_w = sub_w ^ {rcon_of(rc), 24'h000000};

    assign n0 = w0 ^ tmp_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign outkey = {n0, n1, n2, n3};

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 round-key schedule controller: expands one round per cycle into a
// register array, then serves round keys in encrypt or decrypt order.
//
//   state  | meaning
//   IDLE   | no schedule stored, waiting for start
//   EXPAND | computing round key rc+1 from round key rc each cycle
//   READY  | full schedule stored, reads allowed, start restarts
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         dec_mode,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         busy,
    output logic         done,
    output logic         key_valid
);

    logic [1:0]   state;
    logic [3:0]   rc;
    logic [127:0] slots [NUM_ROUNDS+1];
    logic [127:0] cur_key;
    logic [127:0] step_key;
    logic [3:0]   next_slot;
    logic         start_ok;
    logic         last_round;
    logic         rd_ok;
    logic         idx_in_range;
    logic [3:0]   rd_slot;

    assign cur_key    = slots[rc];
    assign next_slot  = rc + 4'd1;
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_READY));
    assign last_round = (rc == 4'(NUM_ROUNDS - 1));

    // A restart in READY wins over a read issued in the same cycle.
    assign rd_ok        = rd_en && key_valid && !start_ok;
    assign idx_in_range = (rd_idx <= 4'(NUM_ROUNDS));
    assign rd_slot      = dec_mode ? (4'(NUM_ROUNDS) - rd_idx) : rd_idx;

    key_expand_step u_step (
        .inkey  (cur_key),
        .rc     (rc),
        .outkey (step_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rc        <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_READY: begin
                    if (start_ok) begin
                        state     <= ST_EXPAND;
                        rc        <= 4'd0;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    rc <= next_slot;
                    if (last_round) begin
                        state     <= ST_READY;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; key_valid gates all reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start_ok) begin
                slots[0] <= key_in;
            end else if (state == ST_EXPAND) begin
                slots[next_slot] <= step_key;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_key   <= '0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_key <= idx_in_range ? slots[rd_slot] : '0;
            end
        end
    end

endmodule
